// File: rtl/clkdiv_tick_sched.sv
// Per-channel tick scheduler: turns rising edges of a selected clkdiv bit
// into single-cycle enables, so downstream logic stays on clk.
module clkdiv_tick_sched #(
    parameter int CHW = 2,
    parameter int DW  = 32,
    localparam int NCH = 2 ** CHW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  clkdiv,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [4:0]     cfg_sel,
    input  logic           cfg_mode,
    input  logic           cfg_en,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t     state;
        logic [4:0] sel;
        logic       mode;
        logic       prev;
        logic       tick_q;
        logic       busy_q;
        logic       hit;
        logic       cur;
        logic       rise;

        assign hit  = cfg_we && (cfg_ch == CHW'(i));
        assign cur  = clkdiv[sel];
        assign rise = cur & ~prev;

        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= IDLE;
                sel    <= '0;
                mode   <= 1'b0;
                prev   <= 1'b0;
                tick_q <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (hit) begin
                    // Seed prev from the new bit so the switch itself
                    // never looks like an edge; a coincident edge is dropped.
                    sel    <= cfg_sel;
                    mode   <= cfg_mode;
                    prev   <= clkdiv[cfg_sel];
                    state  <= cfg_en ? ARM : IDLE;
                    busy_q <= cfg_en;
                end else begin
                    prev <= cur;
                    unique case (state)
                        IDLE: ;
                        // First edge only aligns the channel to the period.
                        ARM: begin
                            if (rise) state <= RUN;
                        end
                        RUN: begin
                            if (rise) begin
                                tick_q <= 1'b1;
                                if (mode) begin
                                    state  <= IDLE;
                                    busy_q <= 1'b0;
                                end
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end

        assign tick[i] = tick_q;
        assign busy[i] = busy_q;
    end

endmodule

// File: tb/tb_clkdiv_tick_sched.sv
// Directed bench for clkdiv_tick_sched, driven by a local clkdiv counter
// that shares clk and rst with the scheduler.
module tb_clkdiv_tick_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] clkdiv;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [4:0]  cfg_sel = '0;
    logic        cfg_mode = 1'b0;
    logic        cfg_en = 1'b0;
    logic [3:0]  tick;
    logic [3:0]  busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst) clkdiv <= '0;
        else     clkdiv <= clkdiv + 32'd1;
    end

    clkdiv_tick_sched #(.CHW(2), .DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .clkdiv   (clkdiv),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_sel  (cfg_sel),
        .cfg_mode (cfg_mode),
        .cfg_en   (cfg_en),
        .tick     (tick),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input int ch, input int s, input bit m, input bit en);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_sel  = 5'(s);
        cfg_mode = m;
        cfg_en   = en;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic sync(input logic [31:0] mask, input logic [31:0] val);
        int n = 0;
        while (((clkdiv & mask) != val) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_tick(input string tag, input int ch, input int bound,
                             output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick[ch] && (n < bound));
        chk(tag, 32'(tick[ch]), 32'd1);
    endtask

    initial begin
        int n;
        logic [3:0] acc;
        logic e;

        repeat (5) @(negedge clk);
        rst = 1'b0;
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        acc = '0;
        repeat (100) begin
            @(negedge clk);
            acc |= tick | busy;
        end
        chk("idle_quiet", 32'(acc), 32'd0);

        // ch0 periodic on bit 0
        wr(0, 0, 1'b0, 1'b1);
        chk("sel0_busy", 32'(busy[0]), 32'd1);
        chk("sel0_no_early_tick", 32'(tick[0]), 32'd0);
        wait_tick("sel0_first", 0, 6, n);
        chk("sel0_phase", clkdiv & 32'd1, 32'd0);
        for (int k = 0; k < 10; k++) begin
            wait_tick("sel0_seen", 0, 4, n);
            chk("sel0_period", 32'(n), 32'd2);
            chk("sel0_phase", clkdiv & 32'd1, 32'd0);
        end

        // ch1 periodic sel3, ch2 one-shot sel2, ch3 periodic sel3
        sync(32'd15, 32'd0);
        wr(1, 3, 1'b0, 1'b1);
        wr(2, 2, 1'b1, 1'b1);
        wr(3, 3, 1'b0, 1'b1);
        n = 0;
        for (int rel = 3; rel <= 80; rel++) begin
            @(negedge clk);
            e = (rel == 24) || (rel == 40) || (rel == 56) || (rel == 72);
            chk("s3_tick1", 32'(tick[1]), 32'(e));
            chk("s3_tick3", 32'(tick[3]), 32'(e));
            chk("s2_tick2", 32'(tick[2]), 32'(rel == 12));
            chk("s2_busy2", 32'(busy[2]), 32'(rel < 12));
            if (tick[1] && tick[3]) n++;
        end
        chk("overlap_count", 32'(n), 32'd4);

        // reconfigure ch0 to sel4 on a cycle where it would tick
        sync(32'd31, 32'd1);
        wr(0, 4, 1'b0, 1'b1);
        chk("reconf_write_cycle", 32'(tick[0]), 32'd0);
        for (int rel = 1; rel <= 112; rel++) begin
            @(negedge clk);
            e = (rel == 47) || (rel == 79) || (rel == 111);
            chk("reconf_tick0", 32'(tick[0]), 32'(e));
        end

        // disable ch1 on its own edge cycle
        sync(32'd15, 32'd8);
        wr(1, 3, 1'b0, 1'b0);
        chk("dis_tick1", 32'(tick[1]), 32'd0);
        chk("dis_busy1", 32'(busy[1]), 32'd0);
        acc = '0;
        repeat (40) begin
            @(negedge clk);
            acc[0] |= tick[1] | busy[1];
        end
        chk("dis_quiet1", 32'(acc[0]), 32'd0);

        // write ch3 while ch0 ticks
        sync(32'd31, 32'd16);
        wr(3, 1, 1'b1, 1'b1);
        chk("coll_tick0", 32'(tick[0]), 32'd1);
        chk("coll_busy3", 32'(busy[3]), 32'd1);
        for (int rel = 1; rel <= 33; rel++) begin
            @(negedge clk);
            chk("coll_tick0_run", 32'(tick[0]), 32'(rel == 32));
            chk("os1_tick3", 32'(tick[3]), 32'(rel == 6));
            chk("os1_busy3", 32'(busy[3]), 32'(rel < 6));
        end

        // reset while ch0 and ch1 run
        wr(1, 3, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("pre_rst_busy", 32'(busy & 4'b0011), 32'd3);
        sync(32'd15, 32'd8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_tick", 32'(tick), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        acc = '0;
        repeat (100) begin
            @(negedge clk);
            acc |= tick | busy;
        end
        chk("postrst_quiet", 32'(acc), 32'd0);

        // long period arms but stays silent; one-shot sel0 recovers
        wr(2, 31, 1'b0, 1'b1);
        chk("sel31_busy", 32'(busy[2]), 32'd1);
        wr(0, 0, 1'b1, 1'b1);
        wait_tick("os0_first", 0, 8, n);
        chk("os0_phase", clkdiv & 32'd1, 32'd0);
        chk("os0_busy_drop", 32'(busy[0]), 32'd0);
        acc = '0;
        repeat (20) begin
            @(negedge clk);
            acc[0] |= tick[0] | busy[0];
            acc[2] |= tick[2];
        end
        chk("os0_once", 32'(acc[0]), 32'd0);
        chk("sel31_silent", 32'(acc[2]), 32'd0);
        chk("sel31_still_busy", 32'(busy[2]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_tick_sched.md
Name: clkdiv_tick_sched

Overview:
Multi-channel tick scheduler for the free-running 32-bit clkdiv counter bus. Each channel is configured at run time to watch one clkdiv bit. On each rising edge of that bit, the channel emits a single-cycle, clk-synchronous enable pulse. Downstream lab logic (display scan, debounce, LED blink) uses these enables instead of clocking registers from divided clocks, so the whole design stays on the single clk domain.

Parameters:
CHW, 2, channel-index width; number of channels NCH = 2**CHW (default 4)
DW, 32, clkdiv bus width; bit select is 5 bits for DW=32

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
clkdiv  input  DW  free-running counter from the clkdiv module (same clk, same rst)
cfg_we  input  1  configuration write strobe, one cycle
cfg_ch  input  CHW  channel addressed by the write
cfg_sel  input  5  clkdiv bit index to watch
cfg_mode  input  1  0 = periodic, 1 = one-shot
cfg_en  input  1  1 = arm channel, 0 = disable channel
tick  output  NCH  per-channel one-cycle enable pulse, registered
busy  output  NCH  channel is in ARM or RUN

Behaviour:
- Reset (rst=1 at a clk edge):
  - all channels go to IDLE; sel=0, mode=0; prev-bit register = 0
  - tick = 0, busy = 0
  - rst has priority over cfg_we.
- Per-channel registers: sel[4:0], mode, state (IDLE/ARM/RUN), prev.
- Every cycle, prev <= clkdiv[sel], using the sel value as updated in this cycle.
- Rising edge: edge = clkdiv[sel] & ~prev, evaluated with the current registered sel.
- Write (cfg_we=1):
  - addressed channel loads sel and mode.
  - prev <= clkdiv[cfg_sel], so the new selection produces no spurious edge.
  - cfg_en=1: state <= ARM. This applies from any state, including re-arm during RUN.
  - cfg_en=0: state <= IDLE.
  - Same-cycle edge on the addressed channel is ignored; the write wins and no tick is produced.
- State transitions:
  - IDLE: edges ignored.
  - ARM: first edge -> RUN, no tick. The discarded edge aligns the channel so the first tick follows a full period of the selected bit.
  - RUN, edge detected at clk edge k: tick[i]=1 during the cycle after edge k, for exactly one cycle.
  - RUN, mode=1: state <= IDLE at edge k. The tick still appears in the following cycle.
  - RUN, mode=0: remains in RUN.
- Outputs:
  - busy[i] = (state != IDLE), registered with the state.
  - Tick latency: 1 cycle after the clk edge where the selected bit is first sampled high.
  - Periodic spacing: 2^(sel+1) cycles.
- Boundary conditions:
  - sel=0: tick every 2 cycles.
  - sel=31: a legal, very long period.
  - A tick already registered before a disable/re-arm write still appears once; no further ticks follow.
  - Channels are independent. Multiple tick bits may be high in the same cycle; there is no arbitration.
  - Reset mid-operation aborts all channels immediately. tick=0 from the next cycle.

Test Plan:
- Reset/idle: drive clkdiv from a real clkdiv instance sharing rst. Hold rst 5 cycles, release, run 100 cycles with no writes -> tick=0, busy=0 throughout.
- Periodic, sel=0: write ch0 (sel=0, mode=0, en=1) -> busy[0]=1 the next cycle. After the first clkdiv[0] rise is discarded, tick[0] pulses one cycle every 2 cycles. Check 10 consecutive pulses.
- Periodic, sel=3 on ch1 with one-shot, sel=2 on ch2, in the same run:
  - tick[1] pulses every 16 cycles, each 1 cycle after clkdiv[3] rises.
  - tick[2] pulses exactly once, 8 cycles after the aligning edge; busy[2] = 0 from that cycle onward.
  - Overlapping ticks on both channels are both seen.
- Reconfigure during RUN: with ch0 running sel=0, write ch0 sel=4 -> no tick in the write cycle. The next tick comes 1 cycle after the second clkdiv[4] rise (aligning edge discarded), then every 32 cycles.
- Disable and collision: write ch1 en=0 in the same cycle its edge is detected -> no tick afterwards, busy[1]=0 next cycle. Write to ch3 while ch0 ticks -> ch0 unaffected.
- Reset mid-run: assert rst for 1 cycle while ch0 and ch1 are in RUN -> tick=0, busy=0 from the next cycle. No ticks until channels are re-armed by a write.
